// File: rtl/ch3_wave_if.sv
// Wave-RAM read port between the channel-3 playback engine and the wave RAM.
// Read data is expected one cycle after wave_rd is sampled high.
interface ch3_wave_if #(
    parameter int POS_W = 5
) ();
    logic             wave_rd;
    logic [POS_W-2:0] wave_addr;
    logic [7:0]       wave_data;

    modport master (output wave_rd, output wave_addr, input  wave_data);
    modport slave  (input  wave_rd, input  wave_addr, output wave_data);
endinterface

// File: rtl/ch3_wave_gen.sv
// Channel-3 wave playback: steps through 32 wave-RAM nibbles and drives the volume-shifted sample.
// Define CH3_LEN_CTR_EN to build in the length counter; without it the channel stops only on DAC off or reset.
module ch3_wave_gen #(
    parameter int FREQ_W = 11,
    parameter int POS_W  = 5,
    parameter int LEN_W  = 8
) (
    input  logic              cery_2mhz,
    input  logic              napu_reset,
    input  logic              ch3_trig,
    input  logic              ch3_dac_en,
    input  logic [FREQ_W-1:0] freq,
    input  logic [1:0]        vol,
    input  logic              len_en,
    input  logic              len_wr,
    input  logic [LEN_W-1:0]  len_load,
    input  logic              len_tick,
    ch3_wave_if.master        wave,
    output logic [3:0]        sample,
    output logic              ch3_active,
    output logic [POS_W-1:0]  wave_pos
);

    typedef enum logic [1:0] {IDLE, RUN, FETCH, LATCH} state_t;

    state_t            state;
    logic [FREQ_W-1:0] fcnt;
    logic              refetch;
    logic              trig_ok;
    logic              step;
    logic              len_expire;
    logic [POS_W-1:0]  pos_inc;
    logic [POS_W-1:0]  pos_nxt;
    logic [3:0]        nibble;

    function automatic logic [3:0] vol_shift(input logic [3:0] nib, input logic [1:0] code);
        case (code)
            2'd0:    return 4'd0;
            2'd1:    return nib;
            2'd2:    return nib >> 1;
            default: return nib >> 2;
        endcase
    endfunction

    assign trig_ok = ch3_trig && ch3_dac_en;
    assign step    = (state != IDLE) && (fcnt == '1);
    assign pos_inc = wave_pos + {{(POS_W-1){1'b0}}, 1'b1};
    assign pos_nxt = step ? pos_inc : wave_pos;
    assign nibble  = wave_pos[0] ? wave.wave_data[3:0] : wave.wave_data[7:4];

`ifdef CH3_LEN_CTR_EN
    logic [LEN_W:0] len_cnt;
    logic [LEN_W:0] len_nxt;

    // A trigger suppresses the same-cycle tick; the reload-if-zero rule sees the len_wr value.
    always_comb begin
        len_nxt    = len_cnt;
        len_expire = 1'b0;
        if (len_wr) begin
            len_nxt = {1'b1, {LEN_W{1'b0}}} - {1'b0, len_load};
        end else if (len_tick && len_en && (len_cnt != '0) && !trig_ok) begin
            len_nxt    = len_cnt - {{LEN_W{1'b0}}, 1'b1};
            len_expire = (len_cnt == {{LEN_W{1'b0}}, 1'b1});
        end
        if (trig_ok && (len_nxt == '0)) begin
            len_nxt = {1'b1, {LEN_W{1'b0}}};
        end
    end

    always_ff @(posedge cery_2mhz) begin
        if (!napu_reset) begin
            len_cnt <= '0;
        end else begin
            len_cnt <= len_nxt;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^{len_wr, len_load, len_tick, len_en};
    assign len_expire = 1'b0;
`endif

    always_ff @(posedge cery_2mhz) begin
        if (!napu_reset) begin
            state          <= IDLE;
            fcnt           <= '0;
            wave_pos       <= '0;
            refetch        <= 1'b0;
            sample         <= 4'd0;
            ch3_active     <= 1'b0;
            wave.wave_rd   <= 1'b0;
            wave.wave_addr <= '0;
        end else if (!ch3_dac_en || (len_expire && !ch3_trig)) begin
            state        <= IDLE;
            refetch      <= 1'b0;
            sample       <= 4'd0;
            ch3_active   <= 1'b0;
            wave.wave_rd <= 1'b0;
        end else if (ch3_trig) begin
            state        <= RUN;
            fcnt         <= freq;
            wave_pos     <= '0;
            refetch      <= 1'b0;
            ch3_active   <= 1'b1;
            wave.wave_rd <= 1'b0;
        end else if (state != IDLE) begin
            fcnt         <= step ? freq : fcnt + {{(FREQ_W-1){1'b0}}, 1'b1};
            wave_pos     <= pos_nxt;
            wave.wave_rd <= 1'b0;
            case (state)
                RUN: begin
                    if (step) begin
                        state          <= FETCH;
                        wave.wave_rd   <= 1'b1;
                        wave.wave_addr <= pos_nxt[POS_W-1:1];
                    end
                end
                FETCH: begin
                    state <= LATCH;
                    if (step) refetch <= 1'b1;
                end
                LATCH: begin
                    sample <= vol_shift(nibble, vol);
                    // Position moved while the byte was in flight: fetch the new one straight away.
                    if (step || refetch) begin
                        state          <= FETCH;
                        refetch        <= 1'b0;
                        wave.wave_rd   <= 1'b1;
                        wave.wave_addr <= pos_nxt[POS_W-1:1];
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
